// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   fetch_state_e : fetch sequencer states (IDLE, REQ, DROP)
//   PC_STEP       : byte increment between sequential instruction words
//   ALIGN_MASK    : low PC bits that are forced to zero on a redirect
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned ALIGN_MASK = 3;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head entry is read directly from storage.
//   clk, areset : clock, asynchronous active-high reset
//   push, wdata : write wdata when push (accepted when not full, or full with a pop)
//   pop         : drop the head entry (ignored when empty)
//   flush       : empty the FIFO; wins over push and pop
//   rdata       : head entry
//   full, empty : occupancy flags
//   level       : number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign rdata = mem_q[rd_ptr_q];
  assign level = count_q;

  // Pointer / count update; pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front-end: fetches words over a req/ack memory port, buffers
// {pc, instr} pairs in a prefetch FIFO and hands them to decode with valid/ready.
// A redirect flushes the buffer and restarts fetch at the new (word aligned) PC.
//   clk, areset              : clock, asynchronous active-high reset
//   mem_req, mem_addr        : fetch request and word address to instruction memory
//   mem_ack, mem_rdata       : memory response and fetched word
//   instr_valid, instr,
//   instr_pc, instr_ready    : head of the prefetch buffer towards decode
//   redirect, redirect_pc    : flush and restart fetch
//   level                    : prefetch buffer occupancy
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned   n        = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [n-1:0]  RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    areset,
  output logic                    mem_req,
  output logic [n-1:0]            mem_addr,
  input  logic                    mem_ack,
  input  logic [n-1:0]            mem_rdata,
  output logic                    instr_valid,
  output logic [n-1:0]            instr,
  output logic [n-1:0]            instr_pc,
  input  logic                    instr_ready,
  input  logic                    redirect,
  input  logic [n-1:0]            redirect_pc,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  fetch_state_e   state_q, state_d;
  logic [n-1:0]   fetch_pc_q, fetch_pc_d;
  logic [n-1:0]   mem_addr_q, mem_addr_d;
  logic           mem_req_q, mem_req_d;

  logic           push_en;
  logic           pop_en;
  logic [LW-1:0]  level_next;
  logic [2*n-1:0] fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [LW-1:0]  fifo_level;

  // Redirect discards both the returning word and any consumer pop.
  assign push_en    = (state_q == REQ) && mem_ack && !redirect;
  assign pop_en     = instr_ready && !fifo_empty && !redirect;
  assign level_next = fifo_level + LW'(push_en) - LW'(pop_en);

  sync_fifo #(
    .WIDTH (2 * n),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .areset(areset),
    .push  (push_en),
    .wdata ({fetch_pc_q, mem_rdata}),
    .pop   (pop_en),
    .flush (redirect),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state and fetch address logic.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = 1'b0;

    if (redirect) begin
      fetch_pc_d = redirect_pc & ~n'(ALIGN_MASK);
      if (state_q == IDLE) begin
        state_d = REQ;
      end else if (mem_ack) begin
        state_d = REQ;
      end else begin
        // Request still in flight: its data must be swallowed before refetching.
        state_d = DROP;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_full) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            fetch_pc_d = fetch_pc_q + n'(PC_STEP);
            state_d    = (level_next < LW'(DEPTH)) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (mem_ack) begin
            state_d = (level_next < LW'(DEPTH)) ? REQ : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // The address may only move when no request is outstanding.
    if ((state_q == IDLE) || mem_ack) begin
      mem_addr_d = fetch_pc_d;
    end

    mem_req_d = (state_d != IDLE);
  end

  // State registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_rdata[n-1:0];
  assign instr_pc    = fifo_rdata[2*n-1:n];
  assign level       = fifo_level;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed, table-driven bench for inst_fetch_buffer plus a wrap-around
// instance and an asynchronous reset in the middle of a request.
module tb_inst_fetch_buffer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        areset;
  logic        mem_req, mem_ack, instr_valid, instr_ready, redirect;
  logic [31:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc;
  logic [2:0]  level;

  inst_fetch_buffer #(.n(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .areset(areset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .level(level)
  );

  // Wrap-around instance
  logic        areset_w;
  logic        mem_req_w, mem_ack_w, instr_valid_w, instr_ready_w, redirect_w;
  logic [31:0] mem_addr_w, mem_rdata_w, instr_w, instr_pc_w, redirect_pc_w;
  logic [2:0]  level_w;

  inst_fetch_buffer #(.n(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .areset(areset_w),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w),
    .instr_valid(instr_valid_w), .instr(instr_w), .instr_pc(instr_pc_w), .instr_ready(instr_ready_w),
    .redirect(redirect_w), .redirect_pc(redirect_pc_w), .level(level_w)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Memory image: every word is derived from its address.
  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [2:0]  lvl;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic rdy, input logic redir,
                              input logic [31:0] rpc, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] ipc, input logic [2:0] lvl);
    vec_t v;
    v.ack = ack; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc; v.lvl = lvl;
    return v;
  endfunction

  localparam int NV = 28;
  vec_t tbl [NV];

  initial begin
    // Expected values are the outputs after the clock edge that consumed the inputs.
    //            ack  rdy  rdr  rpc            req  addr           vld  ipc            lvl
    tbl[0]  = mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h0000_0000,1'b0,32'h0,         3'd0); // IDLE->REQ
    tbl[1]  = mk(1'b1,1'b1,1'b0,32'h0,         1'b1,32'h0000_0004,1'b1,32'h0000_0000,3'd1);
    tbl[2]  = mk(1'b1,1'b1,1'b0,32'h0,         1'b1,32'h0000_0008,1'b1,32'h0000_0004,3'd1);
    tbl[3]  = mk(1'b1,1'b1,1'b0,32'h0,         1'b1,32'h0000_000C,1'b1,32'h0000_0008,3'd1);
    tbl[4]  = mk(1'b1,1'b0,1'b0,32'h0,         1'b1,32'h0000_0010,1'b1,32'h0000_0008,3'd2); // stall core
    tbl[5]  = mk(1'b1,1'b0,1'b0,32'h0,         1'b1,32'h0000_0014,1'b1,32'h0000_0008,3'd3);
    tbl[6]  = mk(1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0000_0018,1'b1,32'h0000_0008,3'd4); // full -> IDLE
    tbl[7]  = mk(1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0000_0018,1'b1,32'h0000_0008,3'd4); // ack ignored
    tbl[8]  = mk(1'b0,1'b1,1'b0,32'h0,         1'b0,32'h0000_0018,1'b1,32'h0000_000C,3'd3); // one pop
    tbl[9]  = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0000_0018,1'b1,32'h0000_000C,3'd3); // one new req
    tbl[10] = mk(1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0000_001C,1'b1,32'h0000_000C,3'd4);
    tbl[11] = mk(1'b0,1'b1,1'b0,32'h0,         1'b0,32'h0000_001C,1'b1,32'h0000_0010,3'd3); // drain
    tbl[12] = mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h0000_001C,1'b1,32'h0000_0014,3'd2); // slow mem
    tbl[13] = mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h0000_001C,1'b1,32'h0000_0018,3'd1);
    tbl[14] = mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h0000_001C,1'b0,32'h0,         3'd0);
    tbl[15] = mk(1'b1,1'b1,1'b0,32'h0,         1'b1,32'h0000_0020,1'b1,32'h0000_001C,3'd1); // ack after 3
    tbl[16] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0000_0020,1'b1,32'h0000_001C,3'd1);
    tbl[17] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0000_0020,1'b1,32'h0000_001C,3'd1);
    tbl[18] = mk(1'b0,1'b1,1'b1,32'h0000_0100, 1'b1,32'h0000_0020,1'b0,32'h0,         3'd0); // redirect pending
    tbl[19] = mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0000_0020,1'b0,32'h0,         3'd0); // DROP holds
    tbl[20] = mk(1'b1,1'b0,1'b0,32'h0,         1'b1,32'h0000_0100,1'b0,32'h0,         3'd0); // stale data dropped
    tbl[21] = mk(1'b1,1'b0,1'b0,32'h0,         1'b1,32'h0000_0104,1'b1,32'h0000_0100,3'd1);
    tbl[22] = mk(1'b1,1'b1,1'b1,32'h0000_0203, 1'b1,32'h0000_0200,1'b0,32'h0,         3'd0); // redirect+ack+pop
    tbl[23] = mk(1'b1,1'b0,1'b0,32'h0,         1'b1,32'h0000_0204,1'b1,32'h0000_0200,3'd1);
    tbl[24] = mk(1'b0,1'b0,1'b1,32'h0000_0300, 1'b1,32'h0000_0204,1'b0,32'h0,         3'd0); // into DROP
    tbl[25] = mk(1'b0,1'b0,1'b1,32'h0000_0404, 1'b1,32'h0000_0204,1'b0,32'h0,         3'd0); // redirect in DROP
    tbl[26] = mk(1'b1,1'b0,1'b0,32'h0,         1'b1,32'h0000_0404,1'b0,32'h0,         3'd0);
    tbl[27] = mk(1'b1,1'b1,1'b0,32'h0,         1'b1,32'h0000_0408,1'b1,32'h0000_0404,3'd1);
  end

  logic [31:0] w_addr [4];
  logic        w_vld  [4];
  logic [31:0] w_ipc  [4];

  initial begin
    w_addr[0] = 32'hFFFF_FFF8; w_vld[0] = 1'b0; w_ipc[0] = 32'h0;
    w_addr[1] = 32'hFFFF_FFFC; w_vld[1] = 1'b1; w_ipc[1] = 32'hFFFF_FFF8;
    w_addr[2] = 32'h0000_0000; w_vld[2] = 1'b1; w_ipc[2] = 32'hFFFF_FFFC;
    w_addr[3] = 32'h0000_0004; w_vld[3] = 1'b1; w_ipc[3] = 32'h0000_0000;
  end

  initial begin
    areset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    areset_w = 1'b1; mem_ack_w = 1'b0; mem_rdata_w = '0; instr_ready_w = 1'b0;
    redirect_w = 1'b0; redirect_pc_w = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_req",     32'(mem_req),     32'd0);
    chk("rst mem_addr",    mem_addr,         32'h0);
    chk("rst instr_valid", 32'(instr_valid), 32'd0);
    chk("rst instr",       instr,            32'h0);
    chk("rst instr_pc",    instr_pc,         32'h0);
    chk("rst level",       32'(level),       32'd0);
    areset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      mem_ack     = tbl[i].ack;
      mem_rdata   = img(mem_addr);
      instr_ready = tbl[i].rdy;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mem_req", i),     32'(mem_req),     32'(tbl[i].req));
      chk($sformatf("v%0d mem_addr", i),    mem_addr,         tbl[i].addr);
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].vld));
      chk($sformatf("v%0d level", i),       32'(level),       32'(tbl[i].lvl));
      if (tbl[i].vld) begin
        chk($sformatf("v%0d instr_pc", i), instr_pc, tbl[i].ipc);
        chk($sformatf("v%0d instr", i),    instr,    img(tbl[i].ipc));
      end
    end
    mem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;

    // Asynchronous reset while a request to 0x408 is outstanding.
    #2 areset = 1'b1;
    #1;
    chk("async mem_req",     32'(mem_req),     32'd0);
    chk("async mem_addr",    mem_addr,         32'h0);
    chk("async level",       32'(level),       32'd0);
    chk("async instr_valid", 32'(instr_valid), 32'd0);

    // PC wrap from 0xFFFF_FFFC to 0 on a zero-wait memory.
    @(posedge clk);
    #1;
    chk("wrap rst mem_addr", mem_addr_w,   32'hFFFF_FFF8);
    chk("wrap rst mem_req",  32'(mem_req_w), 32'd0);
    areset_w = 1'b0;
    instr_ready_w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ack_w   = 1'b1;
      mem_rdata_w = img(mem_addr_w);
      @(posedge clk);
      #1;
      chk($sformatf("w%0d mem_req", i),     32'(mem_req_w),     32'd1);
      chk($sformatf("w%0d mem_addr", i),    mem_addr_w,         w_addr[i]);
      chk($sformatf("w%0d instr_valid", i), 32'(instr_valid_w), 32'(w_vld[i]));
      if (w_vld[i]) begin
        chk($sformatf("w%0d instr_pc", i), instr_pc_w, w_ipc[i]);
        chk($sformatf("w%0d instr", i),    instr_w,    img(w_ipc[i]));
        chk($sformatf("w%0d level", i),    32'(level_w), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
Instruction fetch front-end placed between the PC logic and the core's decode and register-file stage. It fetches 32-bit words from a variable-latency instruction memory using a req/ack handshake. Fetched {PC, instruction} pairs are buffered in a small FIFO and presented to the core with a valid/ready handshake. Branch and jump redirects flush the buffer and restart fetch at a new PC.

Parameters:
n, 32, data and address width (XLEN)
DEPTH, 4, prefetch FIFO entries (power of 2, ≥2)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  input  1  clock, all state on rising edge
areset  input  1  asynchronous, active-high reset
mem_req  output  1  fetch request to instruction memory
mem_addr  output  n  fetch address, word aligned
mem_ack  input  1  memory response; mem_rdata valid this cycle
mem_rdata  input  n  fetched instruction word
instr_valid  output  1  FIFO head valid
instr  output  n  head instruction
instr_pc  output  n  PC of head instruction
instr_ready  input  1  core consumes head when instr_valid&&instr_ready
redirect  input  1  flush buffer and refetch from redirect_pc
redirect_pc  input  n  new fetch PC; bits [1:0] ignored (treated 0)
level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, state=IDLE, FIFO empty, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, level=0.
- mem_req=1 iff state∈{REQ,DROP}. mem_addr is registered fetch_pc. Both stay stable from the assertion of mem_req until the cycle mem_ack=1.
- Single outstanding request. Issuing a request reserves one FIFO slot, so a push never overflows.
- States:
  IDLE: go to REQ next cycle if level<DEPTH and !redirect; else stay.
  REQ: when mem_ack, push {fetch_pc, mem_rdata} and set fetch_pc+=4. Next state is REQ if level_next<DEPTH, else IDLE. level_next accounts for this cycle's push and pop.
  DROP: an in-flight request has been invalidated. Hold mem_req/mem_addr. When mem_ack, discard data, load mem_addr from fetch_pc, and go to REQ if space, else IDLE.
- Redirect (priority over everything), in the same cycle:
  - Flush FIFO (level=0, instr_valid=0 next cycle).
  - fetch_pc=redirect_pc&~3.
  - Any pop this cycle is ignored.
  - From IDLE: go to REQ.
  - From REQ with !mem_ack: go to DROP.
  - From REQ with mem_ack: discard data, go to REQ at redirect_pc.
  - From DROP: stay DROP (or go to REQ if mem_ack), with the updated PC.
- Latency:
  - First mem_req is 1 cycle after reset release.
  - Ack at cycle t gives instr_valid at t+1.
  - With 0-wait ack (mem_ack in every req cycle), steady-state throughput is 1 instr/cycle.
- FIFO:
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop on a full FIFO is legal. It cannot occur from overfill because of the slot reservation.
  - Pop when empty is ignored.
  - instr and instr_pc are stable while instr_valid&&!instr_ready.
- fetch_pc arithmetic is modulo 2^n; a wrap from 0xFFFF_FFFC to 0 is legal.
- mem_ack outside REQ/DROP is ignored.

Decomposition:
- Package fetch_pkg: state enum {IDLE, REQ, DROP}, PC_STEP=4, ALIGN_MASK.
- Sub-module sync_fifo (parameters WIDTH=2n, DEPTH):
  - push/pop/flush inputs.
  - full/empty/level outputs.
  - head data output.

Test Plan:
- Reset, memory acks every req cycle, instr_ready=1 → mem_addr sequence 0,4,8,… one per cycle; instr_pc lags mem_addr by 1 cycle; instr matches memory image.
- instr_ready=0 with 0-wait memory → exactly 4 pushes, level=4, mem_req=0; raise ready for 1 cycle → level 3, then one new req.
- Memory with 3-cycle ack latency → mem_addr held for 3 cycles; instr_valid rises 1 cycle after each ack.
- Redirect to 0x100 while a req to 0x8 is pending (ack 2 cycles later) → FIFO flushed; the 0x8 data is never presented; next mem_addr=0x100; first instr_pc=0x100.
- Redirect to 0x203 coincident with mem_ack and pop → data dropped, pop ignored, next mem_addr=0x200, level=0.
- RESET_PC=32'hFFFF_FFF8, 0-wait → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; areset asserted mid-request → mem_req=0 immediately, level=0.
